clock_divider_multi: RTL and testbench
======================================

CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 18, meaning the half-period counter width in bits.
REQ-003 SHALL have parameter HP_DEFAULT, default 249999, meaning the reset half-period count (100 Hz from 50 MHz).
REQ-004 SHALL have port CLK_50_MHz  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  NUM_CH  per-channel count enable.
REQ-007 SHALL have port sync  input  1  one-cycle pulse that restarts the phase of all channels.
REQ-008 SHALL have port load  input  1  one-cycle pulse that writes load_value to channel load_ch.
REQ-009 SHALL have port load_ch  input  4  target channel index for load.
REQ-010 SHALL have port load_value  input  CNT_W  new half-period count.
REQ-011 SHALL have port CLK_out  output  NUM_CH  per-channel registered square-wave output.
REQ-012 SHALL have port tick  output  NUM_CH  per-channel one-cycle pulse, coincident with the cycle CLK_out goes 0->1.

Function
REQ-013 Each channel SHALL hold a counter cnt, a half-period register hp and a CLK_out register.
REQ-014 When enable[i]=1 and cnt>=hp, the channel SHALL set cnt<=0 and toggle CLK_out[i]; otherwise, while enabled, it SHALL set cnt<=cnt+1.
REQ-015 Output period SHALL be 2*(hp+1) clock cycles at 50% duty; hp=0 SHALL give CLK_50_MHz/2.
REQ-016 When enable[i]=0, cnt and CLK_out[i] SHALL hold, and tick[i] SHALL be 0.
REQ-017 tick[i] SHALL be high for exactly one cycle per rising transition of CLK_out[i].
REQ-018 A load with load_ch>=NUM_CH SHALL be ignored, with no state change.
REQ-019 sync SHALL set cnt<=0, CLK_out<=0 and tick<=0 on all channels, regardless of enable, and SHALL take priority over counting.
REQ-020 load and sync in the same cycle SHALL both take effect, with load behaving as defined in Configuration.
REQ-021 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-022 hp SHALL range 0..2^CNT_W-1, and cnt SHALL never exceed hp after the cycle in which hp is updated.

Reset
REQ-023 While reset=1 (asynchronous), every channel SHALL hold cnt=0, hp=HP_DEFAULT, CLK_out=0, tick=0 and pending=0.
REQ-024 Reset asserted mid-count SHALL discard the count and any pending load; after release, counting SHALL restart from 0.

Configuration
REQ-025 Macro CLKDIV_GLITCHFREE_LOAD_EN SHALL select the load behaviour.
REQ-026 Without the macro, a load SHALL write hp, clear cnt and clear CLK_out on the next edge, so the new period starts immediately.
REQ-027 With the macro, a load SHALL write a per-channel shadow register and set pending. The shadow value SHALL be copied to hp at that channel's next terminal count (cnt>=hp while enabled), with the toggle occurring normally, and pending SHALL then clear.
REQ-028 With the macro, a second load before application SHALL overwrite the shadow; sync SHALL apply any pending shadow immediately; a disabled channel SHALL retain pending.

Structure
REQ-029 Package clock_divider_pkg SHALL hold the CNT_W default, HP_DEFAULT, maximum channel count (16) and the channel-index type.
REQ-030 Sub-module clock_divider_channel SHALL implement one channel (cnt, hp, shadow, CLK_out, tick), and SHALL be instantiated NUM_CH times by generate.

Verification
REQ-031 Reset release, enable[0]=1, defaults -> first CLK_out[0] rise 250000 cycles later; period 500000 cycles; one tick per period.
REQ-032 No macro: load ch1 value 3 mid-count -> next edge cnt=0 and CLK_out[1]=0; then toggle every 4 cycles; tick every 8 cycles.
REQ-033 Macro: hp=9, load ch0 value 3 at cnt=2 -> toggle at cnt=9 (7 cycles later), then toggle every 4 cycles.
REQ-034 load value 0 -> CLK_out toggles every cycle; tick every 2 cycles.
REQ-035 sync with enable=2'b01 -> both CLK_out=0, cnt=0; load_ch=5 with NUM_CH=2 -> no change on any channel.
REQ-036 reset pulse mid-count with hp loaded as 3 -> CLK_out=0 immediately (asynchronous); after release, period 500000 (HP_DEFAULT restored).

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clock_divider_pkg;
    localparam int CNT_W_DEF      = 18;
    localparam int HP_DEFAULT_DEF = 249999;
    localparam int MAX_CH         = 16;

    typedef logic [3:0] ch_idx_t;
endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, half-period register, square-wave output and rise tick.
// Define CLKDIV_GLITCHFREE_LOAD_EN to defer loads to the next terminal count through a shadow register.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int HP_DEFAULT = HP_DEFAULT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             term;

    // ">=" rather than "==" so a shrinking hp can never strand the counter above it.
    assign term = en && (cnt_q >= hp_q);

`ifdef CLKDIV_GLITCHFREE_LOAD_EN
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;

    always_comb begin
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        out_d     = out_q;
        tick_d    = 1'b0;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (sync) begin
            cnt_d = '0;
            out_d = 1'b0;
            // A load arriving with sync is the newest shadow, so it applies at once.
            if (load) begin
                hp_d      = load_value;
                shadow_d  = load_value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                hp_d      = shadow_q;
                pending_d = 1'b0;
            end
        end else begin
            if (term) begin
                cnt_d  = '0;
                out_d  = ~out_q;
                tick_d = ~out_q;
                if (pending_q) begin
                    hp_d      = shadow_q;
                    pending_d = 1'b0;
                end
            end else if (en) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (load) begin
                shadow_d  = load_value;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= CNT_W'(HP_DEFAULT);
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end
`else
    always_comb begin
        cnt_d  = cnt_q;
        hp_d   = hp_q;
        out_d  = out_q;
        tick_d = 1'b0;
        if (sync) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (term) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = ~out_q;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Immediate load restarts the period from a known low phase.
        if (load) begin
            hp_d   = load_value;
            cnt_d  = '0;
            out_d  = 1'b0;
            tick_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            hp_q   <= CNT_W'(HP_DEFAULT);
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hp_q   <= hp_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent square-wave dividers off one system clock, with shared sync and indexed load.
// Load behaviour is selected by CLKDIV_GLITCHFREE_LOAD_EN (see clock_divider_channel).
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int HP_DEFAULT = HP_DEFAULT_DEF
) (
    input  logic              CLK_50_MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync,
    input  logic              load,
    input  ch_idx_t           load_ch,
    input  logic [CNT_W-1:0]  load_value,
    output logic [NUM_CH-1:0] CLK_out,
    output logic [NUM_CH-1:0] tick
);

    // An out-of-range load_ch matches no channel, so that load is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ld;
        assign ld = load && (load_ch == ch_idx_t'(i));

        clock_divider_channel #(
            .CNT_W      (CNT_W),
            .HP_DEFAULT (HP_DEFAULT)
        ) u_ch (
            .clk        (CLK_50_MHz),
            .rst        (reset),
            .en         (enable[i]),
            .sync       (sync),
            .load       (ld),
            .load_value (load_value),
            .clk_out    (CLK_out[i]),
            .tick       (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi; uses a short reset half-period so full periods fit the run.
module tb_clock_divider_multi;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 18;
    localparam int HPD    = 24;
`ifdef CLKDIV_GLITCHFREE_LOAD_EN
    localparam int HP0_S5 = 3;
`else
    localparam int HP0_S5 = HPD;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] enable;
    logic              sync;
    logic              load;
    logic [3:0]        load_ch;
    logic [CNT_W-1:0]  load_value;
    logic [NUM_CH-1:0] CLK_out;
    logic [NUM_CH-1:0] tick;

    int n_vec  = 0;
    int n_miss = 0;

    clock_divider_multi #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .HP_DEFAULT (HPD)
    ) dut (
        .CLK_50_MHz (clk),
        .reset      (reset),
        .enable     (enable),
        .sync       (sync),
        .load       (load),
        .load_ch    (load_ch),
        .load_value (load_value),
        .CLK_out    (CLK_out),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts negedges until CLK_out[ch] rises (n == bound on timeout), tallying ticks seen.
    task automatic wait_rise(input int ch, input int bound, output int n, output int ticks);
        logic prev;
        prev  = CLK_out[ch];
        n     = 0;
        ticks = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (tick[ch]) ticks++;
            if (!prev && CLK_out[ch]) break;
            prev = CLK_out[ch];
        end
    endtask

    initial begin
        int n, t, k;
        reset = 1'b1; enable = '0; sync = 1'b0; load = 1'b0; load_ch = '0; load_value = '0;
        repeat (3) @(negedge clk);
        chk("reset_clk_out", int'(CLK_out), 0);
        chk("reset_tick", int'(tick), 0);

        // Default half-period from reset release.
        reset = 1'b0; enable = 2'b01;
        wait_rise(0, 200, n, t);
        chk("first_rise", n, HPD + 1);
        chk("first_rise_tick", t, 1);
        chk("ch1_disabled_low", int'(CLK_out[1]), 0);
        wait_rise(0, 200, n, t);
        chk("period", n, 2 * (HPD + 1));
        chk("ticks_per_period", t, 1);

        // Disabled channel freezes high with no ticks.
        enable = 2'b00;
        t = 0;
        repeat (40) begin
            @(negedge clk);
            if (tick[0]) t++;
        end
        chk("hold_out", int'(CLK_out[0]), 1);
        chk("hold_ticks", t, 0);

`ifdef CLKDIV_GLITCHFREE_LOAD_EN
        // hp=9 via load+sync, then load 3 at cnt=2: deferred to terminal count.
        load = 1'b1; load_ch = 4'd0; load_value = 18'd9;
        @(negedge clk);
        load = 1'b0; sync = 1'b1;
        @(negedge clk);
        sync = 1'b0; enable = 2'b01;
        chk("gf_sync_clear", int'(CLK_out), 0);
        repeat (2) @(negedge clk);
        load = 1'b1; load_value = 18'd3;
        @(negedge clk);
        load = 1'b0;
        chk("gf_no_immediate", int'(CLK_out[0]), 0);
        wait_rise(0, 50, n, t);
        chk("gf_deferred_rise", n, 7);
        chk("gf_deferred_tick", t, 1);
        wait_rise(0, 50, n, t);
        chk("gf_new_period", n, 8);
`else
        // Immediate load on ch1 while it is high.
        enable = 2'b11;
        repeat (30) @(negedge clk);
        chk("ch1_high_before_load", int'(CLK_out[1]), 1);
        load = 1'b1; load_ch = 4'd1; load_value = 18'd3;
        @(negedge clk);
        load = 1'b0;
        chk("load_clears_out", int'(CLK_out[1]), 0);
        wait_rise(1, 50, n, t);
        chk("load_first_rise", n, 4);
        chk("load_first_tick", t, 1);
        wait_rise(1, 50, n, t);
        chk("load_period", n, 8);
        chk("load_period_ticks", t, 1);
`endif

        // hp=0 on ch1, load and sync together; ch0 disabled.
        enable = 2'b10; load = 1'b1; load_ch = 4'd1; load_value = 18'd0; sync = 1'b1;
        @(negedge clk);
        load = 1'b0; sync = 1'b0;
        chk("sync_load_out", int'(CLK_out), 0);
        for (k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("hp0_out_%0d", k), int'(CLK_out[1]), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("hp0_tick_%0d", k), int'(tick[1]), (k % 2 == 0) ? 1 : 0);
        end
        chk("hp0_ch0_held", int'(CLK_out[0]), 0);

        // sync with enable=01, then out-of-range loads must change nothing.
        enable = 2'b11;
        repeat (3) @(negedge clk);
        sync = 1'b1; enable = 2'b01;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_out", int'(CLK_out), 0);
        chk("sync_tick", int'(tick), 0);
        load = 1'b1; load_ch = 4'd5; load_value = 18'd1;
        @(negedge clk);
        load_ch = 4'd15;
        @(negedge clk);
        load = 1'b0;
        wait_rise(0, 100, n, t);
        chk("bad_ch_rise", n + 2, HP0_S5 + 1);
        chk("bad_ch_ch1_low", int'(CLK_out[1]), 0);

        // Async reset mid-count with hp=3 restores the default period.
        load = 1'b1; load_ch = 4'd0; load_value = 18'd3; sync = 1'b1; enable = 2'b01;
        @(negedge clk);
        load = 1'b0; sync = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_high", int'(CLK_out[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_out", int'(CLK_out), 0);
        chk("async_reset_tick", int'(tick), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_rise(0, 200, n, t);
        chk("post_reset_rise", n, HPD + 1);
        wait_rise(0, 200, n, t);
        chk("post_reset_period", n, 2 * (HPD + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
